charlcd_bus: RTL and testbench

//  Parametrised HD44780/WEH-style parallel bus engine, successor to the single-shot OLED driver.

---
 rtl/charlcd_bus.sv | 229 ++++++++++++++++++++++
 tb/tb_charlcd_bus.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/charlcd_bus.sv
// charlcd_bus: HD44780-style parallel character-LCD bus engine.
//
// Commands {wait_busy, rs, data[7:0]} are queued in a FIFO (valid/ready) and
// played out as E/RS/RW/DB write cycles, 8-bit or 4-bit (high nibble first).
// Commands flagged wait_busy are followed by busy-flag polling until DB7 reads 0.
// The tristate pad lives in the top level; this block exposes db_out/db_oe/db_in.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   in_valid/in_ready  command handshake, in_cmd = {wait_busy, rs, data}
//   idle               FIFO empty, FSM idle, power-up complete
//   busy_timeout       sticky busy-poll timeout flag
//   db_out/db_oe/db_in data bus write value, output enable, read value
//   rs_pin/read_pin/enable_pin  RS, R/!W, E strobe
//
// Optional feature: define CHARLCD_BUSY_TIMEOUT_EN to bound busy polling to
// BUSY_TIMEOUT polls per command; otherwise polling is unbounded and
// busy_timeout is tied 0.
//
// state     | meaning
// ----------+-----------------------------------------------
// POWERUP   | power-on delay, outputs at reset values
// IDLE      | waiting for / popping the next command
// W_SETUP   | write: RS/RW/DB set up before E
// W_PULSE   | write: E high
// W_HOLD    | write: E low, pins held
// B_SETUP   | busy poll: read set up before E
// B_PULSE   | busy poll: E high
// B_HOLD    | busy poll: E low, DB7 sampled / decision
module charlcd_bus #(
    parameter int BUS_WIDTH    = 8,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1,
    parameter int POR_CYCLES   = 1024,
    parameter int FIFO_DEPTH   = 16,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [9:0] in_cmd,
    output logic       idle,
    output logic       busy_timeout,
    output logic [7:0] db_out,
    output logic       db_oe,
    input  logic [7:0] db_in,
    output logic       rs_pin,
    output logic       read_pin,
    output logic       enable_pin
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(POR_CYCLES + SETUP_CYCLES + PULSE_CYCLES + HOLD_CYCLES + 1);
    localparam logic [CW-1:0] POR_LD   = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_POWERUP, S_IDLE, S_W_SETUP, S_W_PULSE, S_W_HOLD, S_B_SETUP, S_B_PULSE, S_B_HOLD
    } state_t;

    // ---------------- command FIFO ----------------
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          in_ready_q;
    logic          push, pop;
    state_t        state_q;

    assign push    = in_valid && in_ready_q;
    assign pop     = (state_q == S_IDLE) && (count_q != '0);
    assign count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_cmd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q    <= count_d;
            in_ready_q <= (count_d != DEPTH_C);
        end
    end

    // ---------------- bus FSM ----------------
    logic [CW-1:0] cnt_q;
    logic [9:0]    cmd_q;
    logic          nib_q, busy_q;
    logic          en_q, rd_q, rs_q, oe_q, idle_q;
    logic [7:0]    db_q;
    logic [7:0]    wr_db;
    logic          last, second, samp, busy_now;

    assign last   = (cnt_q == '0);
    // second (or only) transfer of the current byte
    assign second = (BUS_WIDTH != 4) || nib_q;
    assign wr_db  = (BUS_WIDTH != 4) ? cmd_q[7:0] :
                    (nib_q ? {cmd_q[3:0], 4'b0} : {cmd_q[7:4], 4'b0});
    // Pins lag the state by one cycle, so the first B_HOLD cycle is the last
    // cycle E is actually high on the pin: that is where DB7 is taken.
    assign samp     = (state_q == S_B_HOLD) && (cnt_q == HOLD_LD) && !nib_q;
    assign busy_now = samp ? db_in[7] : busy_q;

`ifdef CHARLCD_BUSY_TIMEOUT_EN
    localparam int PW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [PW-1:0] TO_LAST = PW'(BUSY_TIMEOUT - 1);
    logic [PW-1:0] polls_q;
    logic          bto_q;
    assign busy_timeout = bto_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = BUSY_TIMEOUT;
    assign busy_timeout   = 1'b0;
`endif
    logic unused_db;
    assign unused_db = ^db_in[6:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_POWERUP;
            cnt_q   <= POR_LD;
            cmd_q   <= '0;
            nib_q   <= 1'b0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            rd_q    <= 1'b1;
            rs_q    <= 1'b0;
            oe_q    <= 1'b0;
            db_q    <= '0;
            idle_q  <= 1'b0;
`ifdef CHARLCD_BUSY_TIMEOUT_EN
            polls_q <= '0;
            bto_q   <= 1'b0;
`endif
        end else begin
            // registered pin image of the current state
            en_q <= 1'b0;
            rd_q <= 1'b1;
            rs_q <= 1'b0;
            oe_q <= 1'b0;
            db_q <= '0;
            case (state_q)
                S_W_SETUP, S_W_PULSE, S_W_HOLD: begin
                    rd_q <= 1'b0;
                    oe_q <= 1'b1;
                    rs_q <= cmd_q[8];
                    db_q <= wr_db;
                    en_q <= (state_q == S_W_PULSE);
                end
                S_B_PULSE: en_q <= 1'b1;
                default: ;
            endcase
            idle_q <= (state_q == S_IDLE) && (count_q == '0) && !push;
            if (samp) busy_q <= db_in[7];
            if (!last) cnt_q <= cnt_q - CW'(1);

            case (state_q)
                S_POWERUP: if (last) state_q <= S_IDLE;
                S_IDLE: if (pop) begin
                    cmd_q   <= mem_q[rd_ptr_q];
                    nib_q   <= 1'b0;
                    state_q <= S_W_SETUP;
                    cnt_q   <= SETUP_LD;
`ifdef CHARLCD_BUSY_TIMEOUT_EN
                    polls_q <= '0;
`endif
                end
                S_W_SETUP: if (last) begin state_q <= S_W_PULSE; cnt_q <= PULSE_LD; end
                S_W_PULSE: if (last) begin state_q <= S_W_HOLD;  cnt_q <= HOLD_LD;  end
                S_W_HOLD: if (last) begin
                    cnt_q <= SETUP_LD;
                    if (!second) begin
                        nib_q   <= 1'b1;
                        state_q <= S_W_SETUP;
                    end else if (cmd_q[9]) begin
                        nib_q   <= 1'b0;
                        state_q <= S_B_SETUP;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_B_SETUP: if (last) begin state_q <= S_B_PULSE; cnt_q <= PULSE_LD; end
                S_B_PULSE: if (last) begin state_q <= S_B_HOLD;  cnt_q <= HOLD_LD;  end
                S_B_HOLD: if (last) begin
                    cnt_q <= SETUP_LD;
                    if (!second) begin
                        nib_q   <= 1'b1;
                        state_q <= S_B_SETUP;
                    end else begin
                        nib_q <= 1'b0;
                        if (!busy_now) begin
                            state_q <= S_IDLE;
`ifdef CHARLCD_BUSY_TIMEOUT_EN
                        end else if (polls_q == TO_LAST) begin
                            bto_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            polls_q <= polls_q + PW'(1);
                            state_q <= S_B_SETUP;
`else
                        end else begin
                            state_q <= S_B_SETUP;
`endif
                        end
                    end
                end
                default: state_q <= S_POWERUP;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign idle       = idle_q;
    assign db_out     = db_q;
    assign db_oe      = oe_q;
    assign rs_pin     = rs_q;
    assign read_pin   = rd_q;
    assign enable_pin = en_q;
endmodule

// File: tb/tb_charlcd_bus.sv
// Directed bench for charlcd_bus: an 8-bit instance (a_*) and a 4-bit
// instance (b_*), both POR_CYCLES=16, FIFO_DEPTH=4, BUSY_TIMEOUT=4.
module tb_charlcd_bus;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       a_valid, a_ready, a_idle, a_bto, a_oe, a_rs, a_rd, a_en;
    logic [9:0] a_cmd;
    logic [7:0] a_db, a_dbin;
    logic       b_valid, b_ready, b_idle, b_bto, b_oe, b_rs, b_rd, b_en;
    logic [9:0] b_cmd;
    logic [7:0] b_db, b_dbin;

    int pass_cnt = 0;
    int total    = 0;

    charlcd_bus #(.BUS_WIDTH(8), .SETUP_CYCLES(1), .PULSE_CYCLES(2), .HOLD_CYCLES(1),
                  .POR_CYCLES(16), .FIFO_DEPTH(4), .BUSY_TIMEOUT(4)) dut_a (
        .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(a_ready), .in_cmd(a_cmd),
        .idle(a_idle), .busy_timeout(a_bto), .db_out(a_db), .db_oe(a_oe), .db_in(a_dbin),
        .rs_pin(a_rs), .read_pin(a_rd), .enable_pin(a_en));

    charlcd_bus #(.BUS_WIDTH(4), .SETUP_CYCLES(1), .PULSE_CYCLES(2), .HOLD_CYCLES(1),
                  .POR_CYCLES(16), .FIFO_DEPTH(4), .BUSY_TIMEOUT(4)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ready), .in_cmd(b_cmd),
        .idle(b_idle), .busy_timeout(b_bto), .db_out(b_db), .db_oe(b_oe), .db_in(b_dbin),
        .rs_pin(b_rs), .read_pin(b_rd), .enable_pin(b_en));

    // pulse records captured at each E rising edge
    logic       a_prev_e = 1'b0, b_prev_e = 1'b0;
    int         a_run = 0;
    logic [7:0] a_q_db[$];
    logic       a_q_rd[$], a_q_oe[$], a_q_rs[$];
    int         a_q_w[$];
    logic [7:0] b_q_db[$];
    logic       b_q_rd[$], b_q_rs[$];

    task automatic tick();
        @(negedge clk);
        if (a_en && !a_prev_e) begin
            a_q_db.push_back(a_db); a_q_rd.push_back(a_rd);
            a_q_oe.push_back(a_oe); a_q_rs.push_back(a_rs);
        end
        if (a_en) a_run++;
        else if (a_prev_e) begin a_q_w.push_back(a_run); a_run = 0; end
        a_prev_e = a_en;
        if (b_en && !b_prev_e) begin
            b_q_db.push_back(b_db); b_q_rd.push_back(b_rd); b_q_rs.push_back(b_rs);
        end
        b_prev_e = b_en;
    endtask

    task automatic clear_q();
        a_q_db.delete(); a_q_rd.delete(); a_q_oe.delete(); a_q_rs.delete(); a_q_w.delete();
        b_q_db.delete(); b_q_rd.delete(); b_q_rs.delete();
        a_run = 0;
    endtask

    function automatic int n_reads();
        int n = 0;
        foreach (a_q_rd[i]) if (a_q_rd[i]) n++;
        return n;
    endfunction

    task automatic push_a(input logic [9:0] c, output bit ok);
        int n = 0;
        ok = 0; a_valid = 1'b1; a_cmd = c;
        while (!ok && n < 20) begin
            if (a_ready) ok = 1;
            tick(); n++;
        end
        a_valid = 1'b0;
    endtask

    task automatic push_b(input logic [9:0] c, output bit ok);
        int n = 0;
        ok = 0; b_valid = 1'b1; b_cmd = c;
        while (!ok && n < 20) begin
            if (b_ready) ok = 1;
            tick(); n++;
        end
        b_valid = 1'b0;
    endtask

    task automatic test_reset();
        int e_hi = 0;
        reset = 1'b1; a_valid = 0; b_valid = 0; a_cmd = '0; b_cmd = '0; a_dbin = '0; b_dbin = '0;
        repeat (3) tick();
        total++; if (a_en !== 1'b0)  $display("FAIL reset_en: got %b want 0", a_en);   else pass_cnt++;
        total++; if (a_rd !== 1'b1)  $display("FAIL reset_rd: got %b want 1", a_rd);   else pass_cnt++;
        total++; if (a_rs !== 1'b0)  $display("FAIL reset_rs: got %b want 0", a_rs);   else pass_cnt++;
        total++; if (a_oe !== 1'b0)  $display("FAIL reset_oe: got %b want 0", a_oe);   else pass_cnt++;
        total++; if (a_db !== 8'h00) $display("FAIL reset_db: got %h want 00", a_db);  else pass_cnt++;
        total++; if (a_idle !== 1'b0) $display("FAIL reset_idle: got %b want 0", a_idle); else pass_cnt++;
        total++; if (a_bto !== 1'b0) $display("FAIL reset_bto: got %b want 0", a_bto); else pass_cnt++;
        total++; if (a_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", a_ready); else pass_cnt++;
        reset = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (a_en) e_hi++;
            if (k == 16) begin
                total++; if (a_idle !== 1'b0) $display("FAIL por_idle16: got %b want 0", a_idle); else pass_cnt++;
            end
            if (k == 17) begin
                total++; if (a_idle !== 1'b1) $display("FAIL por_idle17: got %b want 1", a_idle); else pass_cnt++;
                total++; if (b_idle !== 1'b1) $display("FAIL por_idle17_b: got %b want 1", b_idle); else pass_cnt++;
            end
        end
        total++; if (e_hi !== 0) $display("FAIL por_enable: got %0d high cycles want 0", e_hi); else pass_cnt++;
    endtask

    task automatic test_write8();
        bit   ok;
        logic exp_e  [1:6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic exp_oe [1:6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        clear_q();
        push_a(10'h038, ok);
        total++; if (ok !== 1'b1) $display("FAIL w8_accept: got %b want 1", ok); else pass_cnt++;
        for (int k = 1; k <= 6; k++) begin
            tick();
            total++; if (a_en !== exp_e[k]) $display("FAIL w8_en_t%0d: got %b want %b", k, a_en, exp_e[k]); else pass_cnt++;
            total++; if (a_oe !== exp_oe[k]) $display("FAIL w8_oe_t%0d: got %b want %b", k, a_oe, exp_oe[k]); else pass_cnt++;
            total++; if (a_rd !== !exp_oe[k]) $display("FAIL w8_rd_t%0d: got %b want %b", k, a_rd, !exp_oe[k]); else pass_cnt++;
            if (exp_oe[k]) begin
                total++; if (a_db !== 8'h38) $display("FAIL w8_db_t%0d: got %h want 38", k, a_db); else pass_cnt++;
                total++; if (a_rs !== 1'b0) $display("FAIL w8_rs_t%0d: got %b want 0", k, a_rs); else pass_cnt++;
            end
        end
        total++; if (a_idle !== 1'b1) $display("FAIL w8_idle: got %b want 1", a_idle); else pass_cnt++;
        total++; if (a_q_w.size() !== 1) $display("FAIL w8_npulse: got %0d want 1", a_q_w.size()); else pass_cnt++;
        if (a_q_w.size() == 1) begin
            total++; if (a_q_w[0] !== 2) $display("FAIL w8_width: got %0d want 2", a_q_w[0]); else pass_cnt++;
        end
    endtask

    task automatic test_nibble();
        bit ok;
        clear_q();
        push_b(10'h1A5, ok);
        total++; if (ok !== 1'b1) $display("FAIL nib_accept: got %b want 1", ok); else pass_cnt++;
        repeat (20) tick();
        total++; if (b_q_db.size() !== 2) $display("FAIL nib_npulse: got %0d want 2", b_q_db.size()); else pass_cnt++;
        if (b_q_db.size() == 2) begin
            total++; if (b_q_db[0] !== 8'hA0) $display("FAIL nib_db0: got %h want a0", b_q_db[0]); else pass_cnt++;
            total++; if (b_q_db[1] !== 8'h50) $display("FAIL nib_db1: got %h want 50", b_q_db[1]); else pass_cnt++;
            total++; if ({b_q_rs[0], b_q_rs[1]} !== 2'b11) $display("FAIL nib_rs: got %b%b want 11", b_q_rs[0], b_q_rs[1]); else pass_cnt++;
            total++; if ({b_q_rd[0], b_q_rd[1]} !== 2'b00) $display("FAIL nib_rd: got %b%b want 00", b_q_rd[0], b_q_rd[1]); else pass_cnt++;
        end
        total++; if (b_idle !== 1'b1) $display("FAIL nib_idle: got %b want 1", b_idle); else pass_cnt++;
    endtask

    task automatic test_busy_poll();
        bit ok, done = 0, rd_bad = 0;
        a_dbin = 8'h80;
        clear_q();
        push_a(10'h201, ok);
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            if (a_q_w.size() == 4) a_dbin = 8'h00;
            if (a_idle) done = 1;
        end
        total++; if (done !== 1'b1) $display("FAIL poll_done: got %b want 1", done); else pass_cnt++;
        total++; if (n_reads() !== 4) $display("FAIL poll_reads: got %0d want 4", n_reads()); else pass_cnt++;
        total++; if (a_q_rd.size() - n_reads() !== 1) $display("FAIL poll_writes: got %0d want 1", a_q_rd.size() - n_reads()); else pass_cnt++;
        foreach (a_q_rd[i]) if (a_q_rd[i] && (a_q_oe[i] || a_q_rs[i])) rd_bad = 1;
        total++; if (rd_bad !== 1'b0) $display("FAIL poll_read_pins: got bad=%b want 0", rd_bad); else pass_cnt++;
        if (a_q_rd.size() > 0) begin
            total++; if ({a_q_rd[0], a_q_oe[0]} !== 2'b01) $display("FAIL poll_first_write: got rd/oe %b%b want 01", a_q_rd[0], a_q_oe[0]); else pass_cnt++;
        end
    endtask

    task automatic test_fifo_full();
        bit         ok, done = 0;
        int         n_ok = 0;
        logic [7:0] wr[$];
        logic [7:0] exp_wr [5] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
        a_dbin = 8'h80;
        clear_q();
        push_a(10'h2C0, ok); if (ok) n_ok++;
        push_a(10'h0C1, ok); if (ok) n_ok++;
        push_a(10'h0C2, ok); if (ok) n_ok++;
        push_a(10'h0C3, ok); if (ok) n_ok++;
        push_a(10'h0C4, ok); if (ok) n_ok++;
        total++; if (n_ok !== 5) $display("FAIL full_accepts: got %0d want 5", n_ok); else pass_cnt++;
        a_valid = 1'b1; a_cmd = 10'h0C5;
        repeat (10) tick();
        total++; if (a_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", a_ready); else pass_cnt++;
        a_valid = 1'b0;
        a_dbin = 8'h00;
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            if (a_idle) done = 1;
        end
        total++; if (done !== 1'b1) $display("FAIL full_drain: got %b want 1", done); else pass_cnt++;
        foreach (a_q_rd[i]) if (!a_q_rd[i]) wr.push_back(a_q_db[i]);
        total++; if (wr.size() !== 5) $display("FAIL full_nwrites: got %0d want 5", wr.size()); else pass_cnt++;
        if (wr.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                total++; if (wr[i] !== exp_wr[i]) $display("FAIL full_order%0d: got %h want %h", i, wr[i], exp_wr[i]); else pass_cnt++;
            end
        end
        total++; if (a_ready !== 1'b1) $display("FAIL full_ready_after: got %b want 1", a_ready); else pass_cnt++;
    endtask

    task automatic test_timeout();
        bit ok, done = 0;
`ifdef CHARLCD_BUSY_TIMEOUT_EN
        a_dbin = 8'h80;
        clear_q();
        push_a(10'h2C0, ok);
        push_a(10'h0D7, ok);
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            if (a_idle) done = 1;
        end
        total++; if (done !== 1'b1) $display("FAIL to_done: got %b want 1", done); else pass_cnt++;
        total++; if (n_reads() !== 4) $display("FAIL to_reads: got %0d want 4", n_reads()); else pass_cnt++;
        total++; if (a_bto !== 1'b1) $display("FAIL to_flag: got %b want 1", a_bto); else pass_cnt++;
        total++; if (a_q_db.size() !== 6) $display("FAIL to_npulse: got %0d want 6", a_q_db.size()); else pass_cnt++;
        if (a_q_db.size() == 6) begin
            total++; if ({a_q_rd[5], a_q_db[5]} !== {1'b0, 8'hD7}) $display("FAIL to_next_write: got rd=%b db=%h want rd=0 db=d7", a_q_rd[5], a_q_db[5]); else pass_cnt++;
        end
`else
        a_dbin = 8'h80;
        clear_q();
        push_a(10'h2C0, ok);
        for (int i = 0; i < 1000 && !done; i++) begin
            tick();
            if (n_reads() > 100) done = 1;
        end
        total++; if (done !== 1'b1) $display("FAIL unbounded_polls: got %0d want >100", n_reads()); else pass_cnt++;
        total++; if (a_bto !== 1'b0) $display("FAIL unbounded_flag: got %b want 0", a_bto); else pass_cnt++;
        total++; if (a_idle !== 1'b0) $display("FAIL unbounded_idle: got %b want 0", a_idle); else pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid();
        bit ok, seen = 0;
        a_dbin = 8'h80;
        push_a(10'h2C0, ok);
        push_a(10'h0E1, ok);
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            if (a_en) seen = 1;
        end
        total++; if (seen !== 1'b1) $display("FAIL rm_enable_seen: got %b want 1", seen); else pass_cnt++;
        reset = 1'b1;
        tick();
        total++; if (a_en !== 1'b0) $display("FAIL rm_en: got %b want 0", a_en); else pass_cnt++;
        total++; if ({a_rd, a_oe} !== 2'b10) $display("FAIL rm_rd_oe: got %b%b want 10", a_rd, a_oe); else pass_cnt++;
        total++; if (a_ready !== 1'b1) $display("FAIL rm_ready: got %b want 1", a_ready); else pass_cnt++;
        total++; if (a_bto !== 1'b0) $display("FAIL rm_bto: got %b want 0", a_bto); else pass_cnt++;
        reset = 1'b0;
        clear_q();
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 16) begin
                total++; if (a_idle !== 1'b0) $display("FAIL rm_idle16: got %b want 0", a_idle); else pass_cnt++;
            end
            if (k == 17) begin
                total++; if (a_idle !== 1'b1) $display("FAIL rm_idle17: got %b want 1", a_idle); else pass_cnt++;
            end
        end
        total++; if (a_q_db.size() !== 0) $display("FAIL rm_flushed: got %0d pulses want 0", a_q_db.size()); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write8();
        test_nibble();
        test_busy_poll();
        test_fifo_full();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
